// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed seven-segment display scanner:
// FSM encoding, digit count and active-low segment codes ({g,f,e,d,c,b,a}).
package display_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBlank = 2'd1,
        StDrive = 2'd2
    } scan_state_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern ({g,f,e,d,c,b,a}).
module hex_to_seg7
    import display_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/display_scanner.sv
// Four-digit multiplexed seven-segment scanner: advances one digit per display_clk
// rise, inserts BLANK_CYCLES of dark anodes between digits, and snapshots a whole frame.
module display_scanner
    import display_pkg::*;
#(
    parameter int unsigned BLANK_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  display_clk,
    input  logic [15:0]           digits,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    input  logic [NUM_DIGITS-1:0] blank_mask,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam logic [3:0] BLANK_LOAD = 4'(BLANK_CYCLES);

    scan_state_e            state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   dclk_q;
    logic                   rise;
    logic                   snap_en;

    logic [15:0]            snap_digits_q;
    logic [NUM_DIGITS-1:0]  snap_dp_q;
    logic [NUM_DIGITS-1:0]  snap_blank_q;

    logic [3:0]             nibble;
    logic [6:0]             seg_dec;
    logic [NUM_DIGITS-1:0]  an_d;
    logic [6:0]             seg_d;
    logic                   dp_d;

    assign rise = display_clk & ~dclk_q;

    // A rise always wins over the blank countdown, including the cycle it would expire.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        snap_en = 1'b0;
        if (rise) begin
            idx_d   = (state_q == StIdle) ? '0 : idx_q + IDX_W'(1);
            snap_en = (idx_d == '0);
            cnt_d   = BLANK_LOAD;
            state_d = (BLANK_CYCLES == 0) ? StDrive : StBlank;
        end else begin
            case (state_q)
                StIdle:  state_d = StIdle;
                StBlank: begin
                    cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = StDrive;
                    end
                end
                StDrive: state_d = StDrive;
                default: state_d = StIdle;
            endcase
        end
    end

    assign nibble = snap_digits_q[{idx_q, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .hex (nibble),
        .seg (seg_dec)
    );

    always_comb begin
        an_d  = '1;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (state_q == StDrive) begin
            an_d  = snap_blank_q[idx_q] ? '1 : ~(NUM_DIGITS'(1) << idx_q);
            seg_d = seg_dec;
            dp_d  = ~snap_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= 4'd0;
            dclk_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            dclk_q  <= display_clk;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_digits_q <= '0;
            snap_dp_q     <= '0;
            snap_blank_q  <= '0;
        end else if (snap_en) begin
            snap_digits_q <= digits;
            snap_dp_q     <= dp_mask;
            snap_blank_q  <= blank_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= '1;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= an_d;
            seg <= seg_d;
            dp  <= dp_d;
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner: three instances (BLANK_CYCLES 1, 0, 3) against a
// "digit visible once N cycles have passed since its advance" reference model.
module tb_display_scanner;

    logic        clk;
    logic        rst_n;
    logic        display_clk;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic [3:0]  blank_mask;

    logic [3:0]  an_w  [3];
    logic [6:0]  seg_w [3];
    logic        dp_w  [3];

    int checks = 0;
    int errors = 0;

    int unsigned nb [3] = '{1, 0, 3};
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state
    bit          m_active [3];
    int          m_idx    [3];
    int          m_since  [3];
    logic [15:0] m_dig    [3];
    logic [3:0]  m_dpm    [3];
    logic [3:0]  m_blm    [3];
    logic        m_prev   [3];
    logic [3:0]  e_an     [3];
    logic [6:0]  e_seg    [3];
    logic        e_dp     [3];

    display_scanner #(.BLANK_CYCLES(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .display_clk(display_clk), .digits(digits),
        .dp_mask(dp_mask), .blank_mask(blank_mask), .an(an_w[0]), .seg(seg_w[0]), .dp(dp_w[0])
    );
    display_scanner #(.BLANK_CYCLES(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .display_clk(display_clk), .digits(digits),
        .dp_mask(dp_mask), .blank_mask(blank_mask), .an(an_w[1]), .seg(seg_w[1]), .dp(dp_w[1])
    );
    display_scanner #(.BLANK_CYCLES(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .display_clk(display_clk), .digits(digits),
        .dp_mask(dp_mask), .blank_mask(blank_mask), .an(an_w[2]), .seg(seg_w[2]), .dp(dp_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs after an edge reflect the digit situation just before that edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_active[i] <= 1'b0;
                m_idx[i]    <= 0;
                m_since[i]  <= 0;
                m_dig[i]    <= '0;
                m_dpm[i]    <= '0;
                m_blm[i]    <= '0;
                m_prev[i]   <= 1'b1;
                e_an[i]     <= 4'hF;
                e_seg[i]    <= 7'h7F;
                e_dp[i]     <= 1'b1;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (m_active[i] && m_since[i] >= int'(nb[i])) begin
                    e_an[i]  <= m_blm[i][m_idx[i]] ? 4'hF : ~(4'b0001 << m_idx[i]);
                    e_seg[i] <= seg_tab[m_dig[i][4*m_idx[i] +: 4]];
                    e_dp[i]  <= ~m_dpm[i][m_idx[i]];
                end else begin
                    e_an[i]  <= 4'hF;
                    e_seg[i] <= 7'h7F;
                    e_dp[i]  <= 1'b1;
                end
                m_prev[i] <= display_clk;
                if (display_clk && !m_prev[i]) begin
                    m_active[i] <= 1'b1;
                    m_since[i]  <= 0;
                    if (!m_active[i] || m_idx[i] == 3) begin
                        m_idx[i] <= 0;
                        m_dig[i] <= digits;
                        m_dpm[i] <= dp_mask;
                        m_blm[i] <= blank_mask;
                    end else begin
                        m_idx[i] <= m_idx[i] + 1;
                    end
                end else if (m_since[i] < 1000) begin
                    m_since[i] <= m_since[i] + 1;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        display_clk = 1'b0;
        digits      = '0;
        dp_mask     = '0;
        blank_mask  = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({an_w[k], seg_w[k], dp_w[k]} !== {4'hF, 7'h7F, 1'b1}) begin
                errors++;
                $display("FAIL reset inst%0d got an=%b seg=%b dp=%b want an=1111 seg=1111111 dp=1",
                         k, an_w[k], seg_w[k], dp_w[k]);
            end
        end
    endtask

    task automatic test_sequence();
        logic [10:0] seen [$];
        logic [10:0] want [4];
        logic        prev_dark;
        want = '{{4'b1110, 7'b1000000}, {4'b1101, 7'b1111001},
                 {4'b1011, 7'b0001000}, {4'b0111, 7'b0000000}};
        prev_dark = 1'b1;
        do_reset();
        digits = 16'h8A10;
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if ({an_w[k], seg_w[k], dp_w[k]} !== {e_an[k], e_seg[k], e_dp[k]}) begin
                    errors++;
                    $display("FAIL sequence inst%0d c=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                             k, c, an_w[k], seg_w[k], dp_w[k], e_an[k], e_seg[k], e_dp[k]);
                end
            end
            if (an_w[0] != 4'hF && prev_dark) seen.push_back({an_w[0], seg_w[0]});
            prev_dark = (an_w[0] == 4'hF);
            display_clk = (c % 8 == 0);
        end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (seen.size() <= j || seen[j] !== want[j]) begin
                errors++;
                $display("FAIL sequence_order slot %0d got %b want %b", j,
                         (seen.size() > j) ? seen[j] : 11'h7FF, want[j]);
            end
        end
    endtask

    task automatic test_tear();
        do_reset();
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if ({an_w[k], seg_w[k], dp_w[k]} !== {e_an[k], e_seg[k], e_dp[k]}) begin
                    errors++;
                    $display("FAIL tear inst%0d c=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                             k, c, an_w[k], seg_w[k], dp_w[k], e_an[k], e_seg[k], e_dp[k]);
                end
            end
            if (c == 30) begin
                checks++;
                if ({an_w[0], seg_w[0]} !== {4'b0111, 7'b1000000}) begin
                    errors++;
                    $display("FAIL tear_old_frame got an=%b seg=%b want an=0111 seg=1000000",
                             an_w[0], seg_w[0]);
                end
            end
            if (c == 38) begin
                checks++;
                if ({an_w[0], seg_w[0]} !== {4'b1110, 7'b0001110}) begin
                    errors++;
                    $display("FAIL tear_new_frame got an=%b seg=%b want an=1110 seg=0001110",
                             an_w[0], seg_w[0]);
                end
            end
            if (c == 18) digits = 16'hFFFF;
            display_clk = (c % 8 == 0);
        end
    endtask

    task automatic test_masks();
        int bad;
        bit saw_dp;
        bad = 0;
        saw_dp = 1'b0;
        do_reset();
        digits     = 16'($urandom);
        blank_mask = 4'b0100;
        dp_mask    = 4'b0001;
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if ({an_w[k], seg_w[k], dp_w[k]} !== {e_an[k], e_seg[k], e_dp[k]}) begin
                    errors++;
                    $display("FAIL masks inst%0d c=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                             k, c, an_w[k], seg_w[k], dp_w[k], e_an[k], e_seg[k], e_dp[k]);
                end
            end
            if (an_w[0] == 4'b1011) bad++;
            if (dp_w[0] == 1'b0 && an_w[0] != 4'b1110) bad++;
            if (dp_w[0] == 1'b0 && an_w[0] == 4'b1110) saw_dp = 1'b1;
            display_clk = (c % 8 == 0);
        end
        checks++;
        if (bad != 0 || !saw_dp) begin
            errors++;
            $display("FAIL masks_literal got bad=%0d saw_dp=%0d want bad=0 saw_dp=1", bad, saw_dp);
        end
    endtask

    task automatic test_coincident();
        do_reset();
        digits = 16'h7654;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if ({an_w[k], seg_w[k], dp_w[k]} !== {e_an[k], e_seg[k], e_dp[k]}) begin
                    errors++;
                    $display("FAIL coincident inst%0d c=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                             k, c, an_w[k], seg_w[k], dp_w[k], e_an[k], e_seg[k], e_dp[k]);
                end
            end
            if (c == 1 || c == 2) begin
                checks++;
                if (an_w[1] !== ((c == 1) ? 4'b1111 : 4'b1110)) begin
                    errors++;
                    $display("FAIL zero_blank_latency c=%0d got an=%b want %b", c, an_w[1],
                             (c == 1) ? 4'b1111 : 4'b1110);
                end
            end
            if (c == 5 || c == 12) begin
                checks++;
                if (an_w[2] !== ((c == 5) ? 4'b1111 : 4'b1101)) begin
                    errors++;
                    $display("FAIL rise_priority c=%0d got an=%b want %b", c, an_w[2],
                             (c == 5) ? 4'b1111 : 4'b1101);
                end
            end
            display_clk = (c == 0 || c == 3);
        end
    endtask

    task automatic test_async_reset();
        bit reached;
        reached = 1'b0;
        do_reset();
        digits = 16'h4321;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if ({an_w[k], seg_w[k], dp_w[k]} !== {e_an[k], e_seg[k], e_dp[k]}) begin
                    errors++;
                    $display("FAIL pre_reset inst%0d c=%0d got an=%b want an=%b",
                             k, c, an_w[k], e_an[k]);
                end
            end
            if (an_w[0] == 4'b1011) begin
                reached = 1'b1;
                break;
            end
            display_clk = (c % 8 == 0);
        end
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL reach_digit2 got never want an=1011 within 200 cycles");
        end
        #2;
        rst_n       = 1'b0;
        display_clk = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({an_w[k], seg_w[k], dp_w[k]} !== {4'hF, 7'h7F, 1'b1}) begin
                errors++;
                $display("FAIL async_reset inst%0d got an=%b seg=%b dp=%b want an=1111 seg=1111111 dp=1",
                         k, an_w[k], seg_w[k], dp_w[k]);
            end
        end
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if ({an_w[k], seg_w[k], dp_w[k]} !== {e_an[k], e_seg[k], e_dp[k]}) begin
                    errors++;
                    $display("FAIL post_reset inst%0d c=%0d got an=%b want an=%b",
                             k, c, an_w[k], e_an[k]);
                end
            end
            if (c == 10) begin
                checks++;
                if (an_w[1] !== 4'hF) begin
                    errors++;
                    $display("FAIL no_false_rise got an=%b want an=1111", an_w[1]);
                end
            end
            if (c == 19) begin
                checks++;
                if (an_w[1] !== 4'b1110) begin
                    errors++;
                    $display("FAIL first_rise_after_reset got an=%b want an=1110", an_w[1]);
                end
            end
            display_clk = !(c == 12 || c == 13);
        end
    endtask

    task automatic test_held_high();
        do_reset();
        digits = 16'h3210;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if ({an_w[k], seg_w[k], dp_w[k]} !== {e_an[k], e_seg[k], e_dp[k]}) begin
                    errors++;
                    $display("FAIL held_high inst%0d c=%0d got an=%b want an=%b",
                             k, c, an_w[k], e_an[k]);
                end
            end
            if (c == 39) begin
                checks++;
                if ({an_w[0], seg_w[0]} !== {4'b1101, 7'b1111001}) begin
                    errors++;
                    $display("FAIL single_advance got an=%b seg=%b want an=1101 seg=1111001",
                             an_w[0], seg_w[0]);
                end
            end
            display_clk = (c == 0) || (c >= 8 && c < 28);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if ({an_w[k], seg_w[k], dp_w[k]} !== {e_an[k], e_seg[k], e_dp[k]}) begin
                    errors++;
                    $display("FAIL random inst%0d c=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b",
                             k, c, an_w[k], seg_w[k], dp_w[k], e_an[k], e_seg[k], e_dp[k]);
                end
            end
            if ($urandom_range(0, 2) == 0) display_clk = ~display_clk;
            if ($urandom_range(0, 15) == 0) digits = 16'($urandom);
            if ($urandom_range(0, 15) == 0) dp_mask = 4'($urandom);
            if ($urandom_range(0, 15) == 0) blank_mask = 4'($urandom);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        display_clk = 1'b0;
        digits      = '0;
        dp_mask     = '0;
        blank_mask  = '0;
        test_reset();
        test_sequence();
        test_tear();
        test_masks();
        test_coincident();
        test_async_reset();
        test_held_high();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 Parameter BLANK_CYCLES, default 1: number of clk cycles all anodes stay off after each digit advance (range 0-15).
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 display_clk  input  1  digit-advance strobe from the display clock divider, synchronous to clk.
REQ-005 digits  input  16  four hex nibbles; digit i = digits[4i+3:4i].
REQ-006 dp_mask  input  4  bit i=1 lights the decimal point of digit i.
REQ-007 blank_mask  input  4  bit i=1 forces digit i dark (anode off).
REQ-008 an  output  4  active-low anode enables, bit i = digit i.
REQ-009 seg  output  7  active-low cathodes, bit order {g,f,e,d,c,b,a}.
REQ-010 dp  output  1  active-low decimal-point cathode.

Function
REQ-011 Edge detect: rise = display_clk & ~dclk_q; dclk_q SHALL be a register of display_clk.
REQ-012 FSM states: IDLE, BLANK, DRIVE; encoding SHALL be defined in the shared package.
REQ-013 IDLE: an=4'hF, seg=7'h7F, dp=1; a rise SHALL set idx=0, capture the snapshot (REQ-016), and enter BLANK.
REQ-014 Rise in BLANK or DRIVE: idx SHALL advance (3 wraps to 0), blank counter SHALL reload to BLANK_CYCLES, and the FSM SHALL enter BLANK, or DRIVE directly if BLANK_CYCLES=0.
REQ-015 BLANK: outputs all off; counter SHALL decrement each clk cycle; on reaching 0, the FSM SHALL enter DRIVE on the next edge.
REQ-016 Snapshot: digits, dp_mask and blank_mask SHALL be registered only when idx becomes 0, so a 4-digit frame never tears.
REQ-017 DRIVE: an SHALL be one-hot-low at idx unless snap_blank[idx]=1 (then an=4'hF); seg = hex decode of snap nibble idx; dp = ~snap_dp[idx].
REQ-018 All outputs SHALL be registered, with seg/an/dp changing on the same clk edge.
REQ-019 Latency: digit driven exactly BLANK_CYCLES+1 clk edges after the edge that detects the rise.
REQ-020 Rise arriving in the same cycle that the blank counter reaches 0: the rise SHALL take priority (advance idx, reload counter).
REQ-021 An input change outside the snapshot cycle SHALL have no effect on outputs until the next frame start.
REQ-022 display_clk held high SHALL produce exactly one advance.

Reset
REQ-023 rst_n low SHALL asynchronously force state=IDLE, idx=0, counter=0, snapshot=0, dclk_q=1, an=4'hF, seg=7'h7F, dp=1.
REQ-024 dclk_q reset to 1 SHALL suppress a false rise if display_clk is high at reset release.
REQ-025 Reset asserted mid-frame SHALL darken all digits in the same cycle, without waiting for clk.

Structure
REQ-026 Package display_pkg SHALL hold the state encoding, NUM_DIGITS=4, and the 16 segment-code constants.
REQ-027 Hex-to-segment decode SHALL be a combinational sub-module, hex_to_seg7 (4-bit in, 7-bit active-low out).
REQ-028 display_scanner SHALL instantiate hex_to_seg7 once, muxing the snapshot nibble by idx.

Verification
REQ-029 digits=16'h8A10, masks 0, BLANK_CYCLES=1, rises every 8 clks -> an sequence 1110/1101/1011/0111 with seg 1000000/1111001/0001000/0000000, and 1 blank cycle of an=1111 before each.
REQ-030 Change digits 16'h0000->16'hFFFF while idx=2 -> digits 2 and 3 still show 0 (1000000); next frame shows F (0001110).
REQ-031 blank_mask=4'b0100, dp_mask=4'b0001 -> digit 2 slot an=1111; dp=0 only during digit 0.
REQ-032 BLANK_CYCLES=0; rise -> an valid on the next edge; rise coincident with counter=0 with BLANK_CYCLES=3 -> idx advances and the counter reloads.
REQ-033 rst_n low during DRIVE of digit 2, between clk edges -> an=1111 immediately; after release with display_clk high, no advance until a new 0->1 transition.
REQ-034 display_clk held high for 20 clks -> exactly one idx advance.
